// File: rtl/md_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md_unit_pkg                                                          |
// | Shared op codes, state codes and result helper for the mult/div unit |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package md_unit_pkg;

  // md_op encodings, kept in step with the core's shared op-code defines
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MFHI  = 3'd4;
  localparam logic [2:0] MD_MFLO  = 3'd5;
  localparam logic [2:0] MD_MTHI  = 3'd6;
  localparam logic [2:0] MD_MTLO  = 3'd7;

  // FSM state codes
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Pending result; wr=0 marks a divide by zero that must leave HI/LO alone
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wr;
  } md_result_t;

  // mult/multu/div/divu occupy the lower half of the op space
  function automatic logic is_arith(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  // Full result of an arithmetic op, computed in one shot at the start edge
  function automatic md_result_t md_compute(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    md_result_t  r;
    logic [63:0] prod;
    r    = '0;
    prod = '0;
    case (op)
      MD_MULT: begin
        // Sign-extend to 64 bits; the low 64 bits of the product are exact
        prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        r.hi = prod[63:32];
        r.lo = prod[31:0];
        r.wr = 1'b1;
      end
      MD_MULTU: begin
        prod = {32'b0, a} * {32'b0, b};
        r.hi = prod[63:32];
        r.lo = prod[31:0];
        r.wr = 1'b1;
      end
      MD_DIV: begin
        if (b != 32'b0) begin
          r.lo = $signed(a) / $signed(b);
          r.hi = $signed(a) % $signed(b);
          r.wr = 1'b1;
        end
      end
      MD_DIVU: begin
        if (b != 32'b0) begin
          r.lo = a / b;
          r.hi = a % b;
          r.wr = 1'b1;
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_unit_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md_unit_counter                                                      |
// | Loadable down-counter; done_o flags the last busy cycle (count==1)  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module md_unit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] count_q;

  // Load on start, otherwise count down and rest at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign done_o = (count_q == W'(1));

endmodule
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md_unit                                                              |
// | E-stage multiply/divide unit with HI/LO registers and D-stage stall |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_en,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        d_use_md,
  output logic        busy,
  output logic [31:0] md_out,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  logic [0:0]  state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  md_result_t  pend_q, pend_d;

  logic          start;
  logic          done;
  logic [CW-1:0] load_val;

  // A new arithmetic op is only accepted while idle; ops during RUN are dropped
  assign start    = (state_q == ST_IDLE) && md_en && is_arith(md_op);
  // div/divu have bit 1 set in their encoding
  assign load_val = md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);

  md_unit_counter #(
    .W (CW)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (start),
    .load_val_i (load_val),
    .done_o     (done)
  );

  // Next-state: start/latch in IDLE, commit pending to HI/LO on the last RUN cycle
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pend_d  = md_compute(md_op, A, B);
          state_d = ST_RUN;
        end else if (md_en && (md_op == MD_MTHI)) begin
          hi_d = A;
        end else if (md_en && (md_op == MD_MTLO)) begin
          lo_d = A;
        end
      end
      ST_RUN: begin
        if (done) begin
          if (pend_q.wr) begin
            hi_d = pend_q.hi;
            lo_d = pend_q.lo;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and architectural registers; reset aborts any in-flight op
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign md_out   = !md_en               ? 32'b0 :
                    (md_op == MD_MFHI)   ? hi_q  :
                    (md_op == MD_MFLO)   ? lo_q  : 32'b0;
  assign stall_md = d_use_md && (busy || (md_en && is_arith(md_op)));

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_md_unit                                                           |
// | Randomized scoreboard bench for md_unit                              |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_md_unit;

  localparam int N_MULT = 5;
  localparam int N_DIV  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        md_en;
  logic [2:0]  md_op;
  logic [31:0] A, B;
  logic        d_use_md;
  logic        busy;
  logic [31:0] md_out;
  logic        stall_md;
  logic [31:0] hi, lo;

  md_unit #(
    .MULT_CYCLES (N_MULT),
    .DIV_CYCLES  (N_DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .md_en    (md_en),
    .md_op    (md_op),
    .A        (A),
    .B        (B),
    .d_use_md (d_use_md),
    .busy     (busy),
    .md_out   (md_out),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard queues: HI/LO commit results and md_out reads
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } commit_t;
  commit_t     q_commit[$];
  logic [31:0] q_read[$];

  // Reference architectural state
  logic [31:0] ref_hi = 32'b0;
  logic [31:0] ref_lo = 32'b0;

  // Reference arithmetic from plain integer math
  task automatic ref_arith(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] eh, output logic [31:0] el, output bit wr);
    int              sa, sb;
    longint          sp;
    longint unsigned ua, ub, up;
    sa = a; sb = b; ua = 64'(a); ub = 64'(b);
    eh = ref_hi; el = ref_lo; wr = 1'b1;
    case (op)
      3'd0: begin sp = longint'(sa) * longint'(sb); eh = sp[63:32]; el = sp[31:0]; end
      3'd1: begin up = ua * ub; eh = up[63:32]; el = up[31:0]; end
      3'd2: if (b == 0) wr = 1'b0; else begin el = sa / sb; eh = sa % sb; end
      default: if (b == 0) wr = 1'b0; else begin el = a / b; eh = a % b; end
    endcase
  endtask

  // Monitor: compares md_out on every issued op and HI/LO when busy falls
  int run_cnt   = 0;
  bit prev_busy = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      run_cnt   = 0;
      prev_busy = 1'b0;
    end else begin
      if (md_en) begin
        if (q_read.size() == 0) begin
          tests++; fails++;
          $display("FAIL read_underflow: md_out %h with nothing expected", md_out);
        end else begin
          chk("md_out", md_out, q_read.pop_front());
        end
        if (busy) begin
          fails++;
          $display("FAIL op_while_busy: md_en=1 with busy=1 at %0t", $time);
        end
      end
      if (busy) run_cnt++;
      if (prev_busy && !busy) begin
        if (q_commit.size() == 0) begin
          tests++; fails++;
          $display("FAIL commit_underflow: busy fell with nothing expected");
        end else begin
          commit_t c;
          c = q_commit.pop_front();
          chk("commit_hi", hi, c.hi);
          chk("commit_lo", lo, c.lo);
          chk("busy_len", 32'(run_cnt), 32'(c.cyc));
        end
        run_cnt = 0;
      end
      prev_busy = busy;
    end
  end

  // Drive one op from just after a rising edge; returns just after the edge
  // that ends its busy window (i.e. in the first non-busy cycle)
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit dmd);
    logic [31:0] eh, el;
    bit          wr;
    bit          arith;
    int          n;
    commit_t     c;
    arith = (op < 3'd4);
    n     = (op < 3'd2) ? N_MULT : N_DIV;
    md_en = 1'b1; md_op = op; A = a; B = b; d_use_md = dmd;
    q_read.push_back((op == 3'd4) ? ref_hi : (op == 3'd5) ? ref_lo : 32'b0);
    @(negedge clk);
    chk("stall_start", 32'(stall_md), 32'(dmd & arith));
    chk("busy_idle", 32'(busy), 32'd0);
    if (arith) begin
      ref_arith(op, a, b, eh, el, wr);
      if (wr) begin ref_hi = eh; ref_lo = el; end
      c.hi = ref_hi; c.lo = ref_lo; c.cyc = n;
      q_commit.push_back(c);
    end else if (op == 3'd6) begin
      ref_hi = a;
    end else if (op == 3'd7) begin
      ref_lo = a;
    end
    @(posedge clk); #1;
    md_en = 1'b0;
    if (arith) begin
      repeat (n) begin
        @(negedge clk);
        chk("busy_run", 32'(busy), 32'd1);
        chk("stall_run", 32'(stall_md), 32'(dmd));
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    reset = 1'b1; md_en = 1'b0; md_op = 3'd0; A = '0; B = '0; d_use_md = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_stall", 32'(stall_md), 32'd0);
    @(posedge clk); #1;

    // Directed cases
    issue(3'd0, 32'hFFFFFFFE, 32'd3, 1'b1);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);
    issue(3'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
    chk("multu_hi", hi, 32'h00000001);
    chk("multu_lo", lo, 32'hFFFFFFFE);
    issue(3'd2, 32'hFFFFFFF9, 32'd2, 1'b1);
    chk("div_hi", hi, 32'hFFFFFFFF);
    chk("div_lo", lo, 32'hFFFFFFFD);
    issue(3'd3, 32'd7, 32'd0, 1'b0);
    chk("divz_hi", hi, 32'hFFFFFFFF);
    chk("divz_lo", lo, 32'hFFFFFFFD);
    issue(3'd6, 32'h12345678, 32'd0, 1'b1);
    issue(3'd4, 32'd0, 32'd0, 1'b0);
    chk("mthi_hi", hi, 32'h12345678);

    // Reset during the third busy cycle of a divide
    md_en = 1'b1; md_op = 3'd2; A = 32'd100; B = 32'd7; d_use_md = 1'b0;
    q_read.push_back(32'b0);
    @(posedge clk); #1 md_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    ref_hi = 32'b0; ref_lo = 32'b0;
    @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
    issue(3'd0, 32'd6, 32'd7, 1'b0);
    chk("post_rst_lo", lo, 32'd42);

    // Randomized ops, including back-to-back starts as busy falls
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 20));
        2:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
        default: b = $urandom;
      endcase
      if (op == 3'd2 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
      issue(op, a, b, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("commit_q_empty", 32'(q_commit.size()), 32'd0);
    chk("read_q_empty", 32'(q_read.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/md_unit.md
# md_unit

Multiply/divide unit with HI/LO registers for the pipelined MIPS core, sitting in the E stage beside the ALU. It accepts mult/multu/div/divu/mfhi/mflo/mthi/mtlo operations from the controller's decode of `useMultDiv`/`ctrl_start`. It sequences each multiply or divide through a fixed-latency busy window and commits HI/LO at the end. It raises a stall request so the hazard unit freezes D whenever a mult/div-class instruction meets an in-flight operation.

## Interface
- `MULT_CYCLES`, 5, busy cycles for mult/multu (≥1)
- `DIV_CYCLES`, 10, busy cycles for div/divu (≥1)
- `clk`  in  1  core clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `md_en`  in  1  E-stage instruction is mult/div-class (valid qualifier for `md_op`)
- `md_op`  in  3  operation select, encoding from shared defines
- `A`  in  32  forwarded rs value (E stage)
- `B`  in  32  forwarded rt value (E stage)
- `d_use_md`  in  1  D-stage instruction is mult/div-class
- `busy`  out  1  multiply/divide in progress
- `md_out`  out  32  HI for mfhi, LO for mflo, else 0
- `stall_md`  out  1  D-stage stall request
- `hi`, `lo`  out  32 each  architectural HI/LO, for debug/trace

## Operation
- Encoding: MULT=0, MULTU=1, DIV=2, DIVU=3, MFHI=4, MFLO=5, MTHI=6, MTLO=7.
- States: IDLE, RUN. Reset → IDLE, `busy`=0, counter=0, `hi`=`lo`=0, pending result=0.
- IDLE + `md_en` + op∈{0..3}:
  - latch result computed from `A`,`B` into pending regs.
  - load counter with MULT_CYCLES or DIV_CYCLES.
  - go RUN.
- RUN: counter decrements each cycle. On the edge where counter==1, pending → HI/LO, counter→0, go IDLE.
- MTHI/MTLO in IDLE with `md_en`: `hi`/`lo` ← `A` at the edge, no busy.
- MFHI/MFLO: combinational; `md_out` reflects current `hi`/`lo`.
- Any `md_en` op while RUN is ignored; hazard logic prevents it. A bench assertion flags it.
- Arithmetic:
  - mult: signed 32×32→64, HI=[63:32], LO=[31:0]. multu: unsigned.
  - div: LO=quotient truncated toward zero, HI=remainder with sign of dividend. divu: unsigned.
  - Divide by zero: operation still runs full DIV_CYCLES, HI/LO unchanged at commit.
- `stall_md` = `d_use_md` & (`busy` | (`md_en` & op∈{0..3})).

## Timing
- Start edge = end of cycle where op sits in E. `busy`=1 for exactly N following cycles (N = MULT_CYCLES or DIV_CYCLES).
- HI/LO visible in the first cycle with `busy`=0. An mfhi reaching E that cycle reads the new value.
- Back-to-back: a new start is accepted in the same cycle `busy` falls (state IDLE).
- `busy`, `hi`, `lo` are registered. `md_out` and `stall_md` are combinational.
- Asynchronous reset mid-RUN aborts the operation: pending is discarded, HI/LO=0, `busy`=0 immediately, no commit.
- No flush input: a started operation always completes. Exceptions/interrupts are out of scope for this revision.

## Structure
- `md_op` encodings (MD_MULT…MD_MTLO) go in the shared `macro.v` defines, next to the ALU op codes.
- Optional sub-module `md_counter`: loadable down-counter with a `done` pulse. The rest is one FSM plus HI/LO registers.
- Result computation uses synthesizable `*`, `/`, `%` on the latched operands. The cycle count is modeled, not iterative.

## Test plan
- mult A=0xFFFFFFFE (−2), B=3 → `busy` high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu A=0xFFFFFFFF, B=2 → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div A=−7 (0xFFFFFFF9), B=2 → 10 busy cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=0 → 10 busy cycles, HI/LO unchanged.
- Stall: start mult with `d_use_md`=1 on the start cycle and throughout → `stall_md`=1 for 6 cycles total, 0 when `busy` falls. With `d_use_md`=0 → `stall_md`=0 throughout.
- mthi A=0x12345678 then mfhi next cycle → `md_out`=0x12345678, `busy` never asserted.
- Assert `reset` in cycle 3 of a div → `busy`=0 asynchronously, HI=LO=0; next mult runs normally.
